// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source FIFOs for ALU and LSU results feeding one registered
// register-file write port, with bounded ALU starvation. Optional macro: WB_BYPASS_EN.

module wb_arbiter_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic [CW-1:0] cnt_o,
    output logic          empty_o,
    output logic          ready_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic [AW-1:0]           rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign cnt_o   = cnt_q;
    assign empty_o = (cnt_q == '0);
    assign ready_o = (cnt_q != CW'(DEPTH));
endmodule

module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    alu_valid_i,
    output logic                    alu_ready_o,
    input  logic [4:0]              alu_rd_i,
    input  logic [31:0]             alu_wd_i,
    input  logic                    lsu_valid_i,
    output logic                    lsu_ready_o,
    input  logic [4:0]              lsu_rd_i,
    input  logic [31:0]             lsu_wd_i,
    output logic                    regwrite_o,
    output logic [4:0]              rd_o,
    output logic [31:0]             wd_o,
    output logic [$clog2(DEPTH):0]  alu_cnt_o,
    output logic [$clog2(DEPTH):0]  lsu_cnt_o
);
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam int          NSRC  = 2;
    localparam int          ALU   = 0;
    localparam int          LSU   = 1;
    localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wb_ent_t;

    localparam int EW = $bits(wb_ent_t);

    logic [NSRC-1:0]          src_valid, src_ready;
    logic [NSRC-1:0]          push, pop, empty, cand, grant, bypass;
    wb_ent_t [NSRC-1:0]       src_ent, head;
    logic [NSRC-1:0][CW-1:0]  cnt;
    wb_ent_t                  win;
    logic                     sel;

    logic [3:0]  starve_q, starve_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wd_q, wd_d;

    assign src_valid    = {lsu_valid_i, alu_valid_i};
    assign src_ent[ALU] = {alu_rd_i, alu_wd_i};
    assign src_ent[LSU] = {lsu_rd_i, lsu_wd_i};

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        wb_arbiter_fifo #(
            .DEPTH(DEPTH),
            .W    (EW),
            .CW   (CW)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_ni(reset_ni),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .din_i   (src_ent[i]),
            .dout_o  (head[i]),
            .cnt_o   (cnt[i]),
            .empty_o (empty[i]),
            .ready_o (src_ready[i])
        );
    end

    always_comb begin
        cand = ~empty;
`ifdef WB_BYPASS_EN
        // An accepted offer into an empty FIFO competes as if it were already queued.
        cand = cand | (src_valid & src_ready);
`endif
        grant = cand;
        if (&cand) grant = (starve_q == LIMIT) ? 2'b01 : 2'b10;

        bypass = '0;
`ifdef WB_BYPASS_EN
        bypass = grant & empty;
`endif
        pop  = grant & ~empty;
        push = src_valid & src_ready & ~bypass;

        sel = grant[LSU];
        win = bypass[sel] ? src_ent[sel] : head[sel];

        starve_d = starve_q;
        if (!cand[ALU] || grant[ALU]) starve_d = '0;
        else if (starve_q != LIMIT)   starve_d = starve_q + 4'd1;

        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wd_d       = wd_q;
        if (|grant) begin
            // x0 results still consume the slot but present as a zeroed non-write.
            regwrite_d = (win.rd != 5'd0);
            rd_d       = win.rd;
            wd_d       = regwrite_d ? win.wd : 32'd0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            starve_q   <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wd_q       <= '0;
        end else begin
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wd_q       <= wd_d;
        end
    end

    assign alu_ready_o = src_ready[ALU];
    assign lsu_ready_o = src_ready[LSU];
    assign alu_cnt_o   = cnt[ALU];
    assign lsu_cnt_o   = cnt[LSU];
    assign regwrite_o  = regwrite_q;
    assign rd_o        = rd_q;
    assign wd_o        = wd_q;

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_ni) $onehot0(grant));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!reset_ni) (pop & empty) == '0);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!reset_ni) (push & ~src_ready) == '0);
    a_starve_bound: assert property (@(posedge clk_i) disable iff (!reset_ni) starve_q <= LIMIT);
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios push expected writes; a
// negedge monitor pops and compares every presented register-file write.

module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIM   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic          alu_valid_i, lsu_valid_i;
    logic          alu_ready_o, lsu_ready_o;
    logic [4:0]    alu_rd_i, lsu_rd_i, rd_o;
    logic [31:0]   alu_wd_i, lsu_wd_i, wd_o;
    logic          regwrite_o;
    logic [CW-1:0] alu_cnt_o, lsu_cnt_o;

    ent_t alu_pend[$], lsu_pend[$], exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .alu_valid_i(alu_valid_i),
        .alu_ready_o(alu_ready_o),
        .alu_rd_i   (alu_rd_i),
        .alu_wd_i   (alu_wd_i),
        .lsu_valid_i(lsu_valid_i),
        .lsu_ready_o(lsu_ready_o),
        .lsu_rd_i   (lsu_rd_i),
        .lsu_wd_i   (lsu_wd_i),
        .regwrite_o (regwrite_o),
        .rd_o       (rd_o),
        .wd_o       (wd_o),
        .alu_cnt_o  (alu_cnt_o),
        .lsu_cnt_o  (lsu_cnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Producers: present queue head, hold it until the handshake edge.
    initial begin : alu_drv
        bit acc;
        alu_valid_i = 1'b0; alu_rd_i = '0; alu_wd_i = '0;
        forever begin
            @(negedge clk_i);
            acc = alu_valid_i && alu_ready_o && reset_ni;
            @(posedge clk_i);
            #1;
            if (acc && alu_pend.size() > 0) void'(alu_pend.pop_front());
            if (alu_pend.size() > 0 && reset_ni) begin
                alu_valid_i = 1'b1;
                {alu_rd_i, alu_wd_i} = alu_pend[0];
            end else alu_valid_i = 1'b0;
        end
    end

    initial begin : lsu_drv
        bit acc;
        lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_wd_i = '0;
        forever begin
            @(negedge clk_i);
            acc = lsu_valid_i && lsu_ready_o && reset_ni;
            @(posedge clk_i);
            #1;
            if (acc && lsu_pend.size() > 0) void'(lsu_pend.pop_front());
            if (lsu_pend.size() > 0 && reset_ni) begin
                lsu_valid_i = 1'b1;
                {lsu_rd_i, lsu_wd_i} = lsu_pend[0];
            end else lsu_valid_i = 1'b0;
        end
    end

    always @(negedge clk_i) begin
        if (reset_ni) begin
            chk("alu_ready_rule", 64'(alu_ready_o), 64'(alu_cnt_o != CW'(DEPTH)));
            chk("lsu_ready_rule", 64'(lsu_ready_o), 64'(lsu_cnt_o != CW'(DEPTH)));
            if (regwrite_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_write: actual rd=%0d wd=%0h required none", rd_o, wd_o);
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("write_rd_wd", 64'({rd_o, wd_o}), 64'(e));
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((alu_pend.size() != 0 || lsu_pend.size() != 0 || exp_q.size() != 0 ||
                alu_cnt_o != 0 || lsu_cnt_o != 0 || alu_valid_i || lsu_valid_i) && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (t >= 300) begin
            n_err++;
            $display("FAIL %s_timeout: actual=%0d cycles required <300", name, t);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_regwrite", 64'(regwrite_o), 64'd0);
        chk("rst_rd", 64'(rd_o), 64'd0);
        chk("rst_wd", 64'(wd_o), 64'd0);
        chk("rst_alu_cnt", 64'(alu_cnt_o), 64'd0);
        chk("rst_lsu_cnt", 64'(lsu_cnt_o), 64'd0);
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("rst_lsu_ready", 64'(lsu_ready_o), 64'd1);

        // Single ALU write and its latency
        alu_pend.push_back({5'd5, 32'hDEADBEEF});
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        repeat (2) @(negedge clk_i);
`ifdef WB_BYPASS_EN
        chk("alu_lat_edge1", 64'(regwrite_o), 64'd1);
        @(negedge clk_i);
        chk("alu_lat_edge2", 64'(regwrite_o), 64'd0);
`else
        chk("alu_lat_edge1", 64'(regwrite_o), 64'd0);
        chk("alu_cnt_queued", 64'(alu_cnt_o), 64'd1);
        @(negedge clk_i);
        chk("alu_lat_edge2", 64'(regwrite_o), 64'd1);
`endif
        wait_idle("single_alu");
        chk("hold_rd", 64'(rd_o), 64'd5);
        chk("hold_wd", 64'(wd_o), 64'hDEADBEEF);
        chk("single_alu_cnt", 64'(alu_cnt_o), 64'd0);

        // x0 drop
        lsu_pend.push_back({5'd0, 32'h1234});
        wait_idle("x0_drop");
        chk("x0_rd", 64'(rd_o), 64'd0);
        chk("x0_wd", 64'(wd_o), 64'd0);
        chk("x0_lsu_cnt", 64'(lsu_cnt_o), 64'd0);

        // Streaming both: LSU fills, starvation forces every 5th grant to ALU
        for (int i = 0; i < 3; i++) alu_pend.push_back({5'(20 + i), 32'hA000_0000 + 32'(i)});
        for (int i = 0; i < 12; i++) lsu_pend.push_back({5'(1 + i), 32'hB000_0000 + 32'(i)});
        for (int g = 0; g < 3; g++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back({5'(1 + 4 * g + j), 32'hB000_0000 + 32'(4 * g + j)});
            exp_q.push_back({5'(20 + g), 32'hA000_0000 + 32'(g)});
        end
`ifndef WB_BYPASS_EN
        repeat (7) @(negedge clk_i);
        chk("lsu_full_cnt", 64'(lsu_cnt_o), 64'd2);
        chk("lsu_full_ready", 64'(lsu_ready_o), 64'd0);
        chk("lsu_full_alu_cnt", 64'(alu_cnt_o), 64'd1);
`endif
        wait_idle("starve");

        // Same rd from both sources: LSU first, ALU on the very next cycle
        alu_pend.push_back({5'd7, 32'hA});
        lsu_pend.push_back({5'd7, 32'hB});
        exp_q.push_back({5'd7, 32'hB});
        exp_q.push_back({5'd7, 32'hA});
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk_i);
                t++;
            end while (!regwrite_o && t < 20);
            chk("same_rd_seen", 64'(regwrite_o), 64'd1);
            @(negedge clk_i);
            chk("same_rd_back2back", 64'(regwrite_o), 64'd1);
        end
        wait_idle("same_rd");

        // Mid-operation reset with both FIFOs holding results
        for (int i = 0; i < 2; i++) begin
            alu_pend.push_back({5'(24 + i), 32'hC000_0000 + 32'(i)});
            lsu_pend.push_back({5'(26 + i), 32'hD000_0000 + 32'(i)});
        end
`ifdef WB_BYPASS_EN
        repeat (2) @(negedge clk_i);
        exp_q.push_back({5'd26, 32'hD000_0000});
        exp_q.push_back({5'd27, 32'hD000_0001});
        @(negedge clk_i);
`else
        exp_q.push_back({5'd26, 32'hD000_0000});
        repeat (3) @(negedge clk_i);
`endif
        #2;
        reset_ni = 1'b0;
        alu_pend.delete();
        lsu_pend.delete();
        #1;
        chk("midrst_regwrite_drop", 64'(regwrite_o), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        chk("midrst_alu_cnt", 64'(alu_cnt_o), 64'd0);
        chk("midrst_lsu_cnt", 64'(lsu_cnt_o), 64'd0);
        chk("midrst_alu_ready", 64'(alu_ready_o), 64'd1);
        chk("midrst_lsu_ready", 64'(lsu_ready_o), 64'd1);
        chk("midrst_regwrite", 64'(regwrite_o), 64'd0);
        repeat (10) @(negedge clk_i);

        // Normal operation resumes after reset
        alu_pend.push_back({5'd9, 32'h55});
        exp_q.push_back({5'd9, 32'h55});
        wait_idle("post_reset");
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the single-issue core: it collects results from the single-cycle ALU path and the multi-cycle load/store path and drives the one write port of the integer register file. Each source has its own small FIFO with a valid/ready handshake, so neither producer stalls while the other writes. A bounded-starvation priority scheme selects at most one result per cycle, and the result is presented as a registered write (`regwrite_o`, `rd_o`, `wd_o`).

## Interface
- `DEPTH`, 2: entries per source FIFO; power of two, 2..8.
- `STARVE_LIMIT`, 4: consecutive ALU losses that force an ALU grant; 1..15.
- `clk_i` in 1: core clock, rising edge.
- `reset_ni` in 1: asynchronous, active-low reset.
- `alu_valid_i` in 1: ALU result offered.
- `alu_ready_o` out 1: ALU FIFO can accept.
- `alu_rd_i` in 5: ALU destination register.
- `alu_wd_i` in 32: ALU result data.
- `lsu_valid_i` in 1: LSU result offered.
- `lsu_ready_o` out 1: LSU FIFO can accept.
- `lsu_rd_i` in 5: LSU destination register.
- `lsu_wd_i` in 32: LSU result data.
- `regwrite_o` out 1: register file write enable, registered.
- `rd_o` out 5: register file write address, registered.
- `wd_o` out 32: register file write data, registered.
- `alu_cnt_o` out $clog2(DEPTH)+1: ALU FIFO occupancy.
- `lsu_cnt_o` out $clog2(DEPTH)+1: LSU FIFO occupancy.

## Operation
- Handshake:
  - A transfer occurs on a rising edge where `x_valid_i && x_ready_o`.
  - `x_ready_o = (x_cnt_o != DEPTH)`. It is a combinational function of occupancy only; it never depends on `valid` or on a same-cycle pop.
  - A `valid` with `ready=0` is ignored. The producer must hold it.
- FIFOs:
  - Each FIFO has independent read and write pointers that wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - Results from the same source are retired strictly in order.
- Arbitration, once per cycle, among non-empty FIFOs:
  - Only one FIFO non-empty: that FIFO wins.
  - Both non-empty: LSU wins unless `starve_cnt == STARVE_LIMIT`, in which case ALU wins.
  - `starve_cnt` is 4 bits. It increments when the ALU FIFO is non-empty and loses. It clears when ALU wins or the ALU FIFO is empty. It saturates at STARVE_LIMIT.
- Retire:
  - The winner's head entry is popped. The output register loads `rd`/`wd` and `regwrite_o <= (rd != 0)`.
  - An entry with `rd == 0` is popped and consumes the cycle, but produces `regwrite_o = 0` with `rd_o = 0` and `wd_o = 0`.
  - No winner: `regwrite_o <= 0`, and `rd_o`/`wd_o` hold their previous values.
- Same `rd` from both sources: both writes are issued on separate cycles in grant order. The later grant's value is final. No merging or cancellation.
- Reset (asynchronous assert, synchronous-safe deassert):
  - Pointers, counts and `starve_cnt` clear to 0.
  - `regwrite_o = 0`, `rd_o = 0`, `wd_o = 0`.
  - Ready outputs read 1 once reset is deasserted.
  - Reset during operation discards all queued results. No partial write is issued.

## Timing
- Latency without bypass:
  - An entry pushed at edge k can be popped at edge k+1 at the earliest.
  - It appears on `regwrite_o` after edge k+1. That is 2 edges from handshake to write.
  - The register file samples it at edge k+2.
- Throughput: one retired result per cycle total, across both sources.
- Both sources streaming continuously: ALU receives at least 1 grant in every STARVE_LIMIT+1 cycles.
- No combinational path from any `*_valid_i` to any `*_ready_o`.

## Configuration
- `WB_BYPASS_EN`: same-cycle bypass into the output register.
- Defined: an offered entry bypasses its FIFO and loads the output register at the same edge as the handshake (1-edge latency) when all of these hold in that cycle:
  - its FIFO is empty;
  - it is accepted;
  - it would win arbitration. For this purpose the bypass candidate counts as a non-empty FIFO.
- Bypassed entries never occupy a FIFO slot. `*_ready_o` behaviour is unchanged.
- Undefined: no bypass path. All entries go through the FIFO with 2-edge latency.

## Test plan
- Single ALU write: reset, then `alu_valid_i=1`, `rd=5`, `wd=0xDEADBEEF` for 1 cycle -> after 2 edges (1 with `WB_BYPASS_EN`), `regwrite_o=1`, `rd_o=5`, `wd_o=0xDEADBEEF` for exactly 1 cycle; both counts return to 0.
- x0 drop: LSU pushes `rd=0`, `wd=0x1234` -> entry is consumed, `regwrite_o` stays 0, `lsu_cnt_o` returns to 0.
- Full and backpressure: DEPTH=2; push LSU `rd=1,2,3` on consecutive cycles while ALU pushes continuously -> `lsu_ready_o=0` when `lsu_cnt_o=2`, the third entry is held and accepted later, and retire order is `rd` 1, 2, 3.
- Starvation: both sources valid every cycle with STARVE_LIMIT=4 -> grant pattern LSU,LSU,LSU,LSU,ALU repeating; no ALU gap longer than 5 cycles.
- Same-rd ordering: ALU and LSU push `rd=7` in the same cycle with `wd=0xA` (ALU) and `wd=0xB` (LSU) -> writes occur `0xB` then `0xA` on consecutive cycles.
- Mid-operation reset: fill both FIFOs, assert `reset_ni=0` between edges -> `regwrite_o` drops to 0 immediately; after release, counts are 0, both readies are 1, and no stale write ever appears.
